mult_share_sched: RTL and testbench



---
 rtl/mult_share_pkg.sv | 29 ++
 rtl/mult_share_sched_booth.sv | 34 +++
 rtl/mult_share_sched.sv | 88 ++++++++
 tb/tb_mult_share_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types, widths and round-robin pick for mult_share_sched
package mult_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MULT  = 2'd1,
      ST_DONE  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam int OPW     = 8;
   localparam int PRODW   = 16;
   localparam int MAX_REQ = 8;

   // Descending scan so the requester closest to ptr is the last one written and wins.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
      int pick;
      int idx;
      pick = 0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            idx = (ptr + i) % n;
            if (req[idx[2:0]]) pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mult_share_sched_booth.sv
// rtl/mult_share_sched_booth.sv - combinational radix-4 Booth signed 8x8 multiplier
module immediate_booth_multiplier_module
   import mult_share_pkg::*;
(
   input  logic signed [OPW-1:0]   rA,
   input  logic signed [OPW-1:0]   rB,
   output logic signed [PRODW-1:0] product
);

   logic [OPW:0]             b_ext;
   logic signed [PRODW-1:0]  a_ext;
   logic signed [PRODW-1:0]  pp;
   logic [2:0]               trip;

   always_comb begin
      b_ext   = {rB, 1'b0};
      a_ext   = {{(PRODW-OPW){rA[OPW-1]}}, rA};
      product = '0;
      pp      = '0;
      trip    = '0;
      for (int i = 0; i < OPW / 2; i++) begin
         trip = b_ext[2*i +: 3];
         case (trip)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
         endcase
         product = product + (pp <<< (2*i));
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin time-sharing of one Booth multiplier among N_REQ requesters
module mult_share_sched
   import mult_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW   = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_REQ-1:0]     Start_Sig,
   input  logic [8*N_REQ-1:0]   A_In,
   input  logic [8*N_REQ-1:0]   B_In,
   output logic [N_REQ-1:0]     Done_Sig,
   output logic [PRODW-1:0]     Product,
   output logic [IDW-1:0]       Grant_Id,
   output logic                 Busy
);

   state_t                  state, state_nxt;
   logic [IDW-1:0]          ptr;
   logic signed [OPW-1:0]   rA, rB;
   logic signed [PRODW-1:0] mult_out;
   logic [MAX_REQ-1:0]      req_vec;
   int                      win;

   always_comb begin
      req_vec              = '0;
      req_vec[N_REQ-1:0]   = Start_Sig;
   end

   always_comb win = rr_pick(req_vec, int'(ptr), N_REQ);

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|Start_Sig) state_nxt = ST_MULT;
         ST_MULT:  state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_CLEAR;
         ST_CLEAR: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign Busy = (state != ST_IDLE);

   // Product doubles as the capture register: loaded leaving MULT, so it shows in DONE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rA       <= '0;
         rB       <= '0;
         Product  <= '0;
         Grant_Id <= '0;
         Done_Sig <= '0;
         ptr      <= '0;
      end else begin
         Done_Sig <= '0;
         case (state)
            ST_IDLE: begin
               if (|Start_Sig) begin
                  rA       <= A_In[OPW*win +: OPW];
                  rB       <= B_In[OPW*win +: OPW];
                  Grant_Id <= IDW'(win);
               end
            end
            ST_MULT: begin
               Product  <= mult_out;
               Done_Sig <= N_REQ'(1) << Grant_Id;
            end
            ST_DONE: begin
               ptr <= (int'(Grant_Id) == N_REQ - 1) ? '0 : Grant_Id + IDW'(1);
            end
            default: ;
         endcase
      end
   end

   immediate_booth_multiplier_module u_mult (
      .rA      (rA),
      .rB      (rB),
      .product (mult_out)
   );

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - directed self-checking bench for mult_share_sched
module tb_mult_share_sched;

   logic        CLK;
   logic        RST;
   logic [3:0]  Start_Sig;
   logic [31:0] A_In;
   logic [31:0] B_In;
   logic [3:0]  Done_Sig;
   logic [15:0] Product;
   logic [2:0]  Grant_Id;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   mult_share_sched #(.N_REQ(4), .IDW(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Start_Sig (Start_Sig),
      .A_In      (A_In),
      .B_In      (B_In),
      .Done_Sig  (Done_Sig),
      .Product   (Product),
      .Grant_Id  (Grant_Id),
      .Busy      (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1; Start_Sig = '0; A_In = '0; B_In = '0;
      tick; tick;
      checks++; if (Done_Sig !== 4'b0000) begin errors++; $display("FAIL reset_done got %b expected 0000", Done_Sig); end
      checks++; if (Product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h expected 0000", Product); end
      checks++; if (Grant_Id !== 3'd0) begin errors++; $display("FAIL reset_grant got %0d expected 0", Grant_Id); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", Busy); end
      RST = 1'b0;
   endtask

   task automatic test_reset_mid_mult;
      A_In = '0; B_In = '0;
      A_In[15:8] = 8'd3; B_In[15:8] = 8'd5;
      Start_Sig = 4'b0010;
      tick;
      checks++; if (Busy !== 1'b1 || Grant_Id !== 3'd1) begin errors++; $display("FAIL mid_grant got busy=%b id=%0d expected busy=1 id=1", Busy, Grant_Id); end
      RST = 1'b1;
      tick;
      checks++; if (Done_Sig !== 4'b0000) begin errors++; $display("FAIL abort_done got %b expected 0000", Done_Sig); end
      checks++; if (Product !== 16'h0000) begin errors++; $display("FAIL abort_product got %h expected 0000", Product); end
      checks++; if (Grant_Id !== 3'd0) begin errors++; $display("FAIL abort_grant got %0d expected 0", Grant_Id); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", Busy); end
      RST = 1'b0;
      tick;
      checks++; if (Done_Sig !== 4'b0000) begin errors++; $display("FAIL rereq_mult_done got %b expected 0000", Done_Sig); end
      tick;
      checks++; if (Done_Sig !== 4'b0010) begin errors++; $display("FAIL rereq_done got %b expected 0010", Done_Sig); end
      checks++; if (Product !== 16'h000F) begin errors++; $display("FAIL rereq_product got %h expected 000f", Product); end
      Start_Sig = 4'b0000;
      tick;
      checks++; if (Done_Sig !== 4'b0000) begin errors++; $display("FAIL rereq_clear_done got %b expected 0000", Done_Sig); end
      tick;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rereq_idle_busy got %b expected 0", Busy); end
   endtask

   task automatic test_signed_extremes;
      logic [7:0]  ta [4];
      logic [7:0]  tb [4];
      logic [15:0] te [4];
      ta = '{8'h80, 8'h7F, 8'hFF, 8'h00};
      tb = '{8'h80, 8'h80, 8'h01, 8'hB3};
      te = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         A_In = '0; B_In = '0;
         A_In[7:0] = ta[i]; B_In[7:0] = tb[i];
         Start_Sig = 4'b0001;
         tick; tick;
         checks++; if (Done_Sig !== 4'b0001) begin errors++; $display("FAIL extreme%0d_done got %b expected 0001", i, Done_Sig); end
         checks++; if (Product !== te[i]) begin errors++; $display("FAIL extreme%0d_product got %h expected %h", i, Product, te[i]); end
         Start_Sig = 4'b0000;
         tick; tick;
      end
   endtask

   task automatic test_all_four;
      logic [3:0] exp_done;
      RST = 1'b1; Start_Sig = '0;
      tick;
      for (int k = 0; k < 4; k++) begin
         A_In[8*k +: 8] = 8'(k + 1);
         B_In[8*k +: 8] = 8'd10;
      end
      Start_Sig = 4'hF;
      RST = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         tick;
         exp_done = (c % 4 == 2) ? (4'b0001 << (c / 4)) : 4'b0000;
         checks++; if (Done_Sig !== exp_done) begin errors++; $display("FAIL all4_done_c%0d got %b expected %b", c, Done_Sig, exp_done); end
         if (c % 4 == 2) begin
            checks++; if (Grant_Id !== 3'(c / 4)) begin errors++; $display("FAIL all4_grant_c%0d got %0d expected %0d", c, Grant_Id, c / 4); end
            checks++; if (Product !== 16'((c / 4 + 1) * 10)) begin errors++; $display("FAIL all4_product_c%0d got %0d expected %0d", c, Product, (c / 4 + 1) * 10); end
            Start_Sig[c / 4] = 1'b0;
         end
      end
      tick; tick;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL all4_final_busy got %b expected 0", Busy); end
   endtask

   task automatic test_hold_req2;
      logic [3:0]  exp_done;
      logic [2:0]  exp_id;
      logic [15:0] exp_prod;
      A_In = '0; B_In = '0;
      A_In[15:8] = 8'd1; B_In[15:8] = 8'd1;
      Start_Sig = 4'b0010;
      tick; tick;
      checks++; if (Done_Sig !== 4'b0010) begin errors++; $display("FAIL hold_setup_done got %b expected 0010", Done_Sig); end
      Start_Sig = 4'b0000;
      tick; tick;
      A_In = '0; B_In = '0;
      A_In[23:16] = 8'd2;  B_In[23:16] = 8'd3;
      A_In[7:0]   = 8'hFC; B_In[7:0]   = 8'd5;
      Start_Sig = 4'b0101;
      for (int c = 1; c <= 16; c++) begin
         tick;
         exp_id   = ((c / 4) % 2 == 0) ? 3'd2 : 3'd0;
         exp_prod = ((c / 4) % 2 == 0) ? 16'h0006 : 16'hFFEC;
         exp_done = (c % 4 == 2) ? (4'b0001 << exp_id) : 4'b0000;
         checks++; if (Done_Sig !== exp_done) begin errors++; $display("FAIL hold_done_c%0d got %b expected %b", c, Done_Sig, exp_done); end
         if (c % 4 == 2) begin
            checks++; if (Grant_Id !== exp_id) begin errors++; $display("FAIL hold_grant_c%0d got %0d expected %0d", c, Grant_Id, exp_id); end
            checks++; if (Product !== exp_prod) begin errors++; $display("FAIL hold_product_c%0d got %h expected %h", c, Product, exp_prod); end
         end
         if (c == 15) Start_Sig = 4'b0000;
      end
      tick;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL hold_final_busy got %b expected 0", Busy); end
   endtask

   task automatic test_operand_change;
      A_In = '0; B_In = '0;
      A_In[31:24] = 8'd7; B_In[31:24] = 8'hF7;
      Start_Sig = 4'b1000;
      tick;
      A_In[31:24] = 8'd100;
      tick;
      checks++; if (Done_Sig !== 4'b1000) begin errors++; $display("FAIL opchg_done got %b expected 1000", Done_Sig); end
      checks++; if (Product !== 16'hFFC1) begin errors++; $display("FAIL opchg_product got %h expected ffc1", Product); end
      Start_Sig = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (Product !== 16'hFFC1) begin errors++; $display("FAIL opchg_hold%0d got %h expected ffc1", i, Product); end
      end
   endtask

   task automatic test_drop_in_mult;
      A_In = '0; B_In = '0;
      A_In[15:8] = 8'hFA; B_In[15:8] = 8'hF9;
      Start_Sig = 4'b0010;
      tick;
      Start_Sig = 4'b0000;
      tick;
      checks++; if (Done_Sig !== 4'b0010) begin errors++; $display("FAIL drop_done got %b expected 0010", Done_Sig); end
      checks++; if (Product !== 16'h002A) begin errors++; $display("FAIL drop_product got %h expected 002a", Product); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL drop_busy_done got %b expected 1", Busy); end
      tick;
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL drop_busy_clear got %b expected 1", Busy); end
      checks++; if (Done_Sig !== 4'b0000) begin errors++; $display("FAIL drop_clear_done got %b expected 0000", Done_Sig); end
      tick;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %b expected 0", Busy); end
      tick;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL drop_no_regrant got %b expected 0", Busy); end
      checks++; if (Grant_Id !== 3'd1) begin errors++; $display("FAIL drop_grant_kept got %0d expected 1", Grant_Id); end
   endtask

   initial begin
      RST = 1'b1; Start_Sig = '0; A_In = '0; B_In = '0;
      test_reset;
      test_reset_mid_mult;
      test_signed_extremes;
      test_all_four;
      test_hold_req2;
      test_operand_change;
      test_drop_in_mult;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
